// File: rtl/dot_position_ctrl.sv
// dot_position_ctrl: pushbutton / switch-load control for the plot dot.
// Four debounced buttons give single steps plus auto-repeat. A level load
// writes an absolute, clamped position. The coordinate changes only on
// frame_tick, so the display never sees it move mid-frame.

module dot_btn_lane #(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    input  logic warm,
    input  logic frame_tick,
    input  logic load,
    output logic step
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] H_ARM   = HW'(REPEAT_DELAY - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(REPEAT_RATE - 1);

    logic [1:0]    sync;
    logic          synced, db, armed, flip, press_edge, pressed;
    logic [CW-1:0] cnt;
    logic          req, hold_act, rep_hit;
    logic [HW-1:0] h;
    logic [PW-1:0] ph, ph_next;

    assign synced     = sync[1];
    assign flip       = (synced != db) && (cnt == DB_LAST);
    // A button held through reset never produces an edge until it has been
    // seen released once (armed).
    assign press_edge = flip && !synced && armed;
    assign pressed    = !db;
    assign ph_next    = (ph == PH_LAST) ? '0 : ph + 1'b1;
    // h saturates at REPEAT_DELAY; ph carries the repeat phase from there on.
    assign rep_hit    = hold_act && pressed &&
                        ((h == H_ARM) || ((h == H_SAT) && (ph == '0)));
    assign step       = frame_tick && !load && (req || rep_hit);

    // Two-flop synchronizer, idles released.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], btn_raw_n};

    // Debounce: state follows the synced input after DB_CYCLES unequal cycles.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              begin db <= 1'b1; cnt <= '0; end
        else if (synced == db)   cnt <= '0;
        else if (flip)           begin db <= synced; cnt <= '0; end
        else                     cnt <= cnt + 1'b1;

    // Arm once the (valid) synced input shows the button released.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)               armed <= 1'b0;
        else if (warm && synced)  armed <= 1'b1;

    // Step request and hold/repeat tracking, advanced on frame ticks.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req      <= 1'b0;
            hold_act <= 1'b0;
            h        <= '0;
            ph       <= '0;
        end else begin
            if (!pressed) begin
                hold_act <= 1'b0;
                h        <= '0;
                ph       <= '0;
            end else if (frame_tick && hold_act) begin
                if (h == H_ARM || h == H_SAT) ph <= ph_next;
                if (h != H_SAT)               h  <= h + 1'b1;
            end
            if (frame_tick) begin
                // A load tick discards the request without starting a hold.
                if (req && !load) begin
                    hold_act <= pressed;
                    h        <= '0;
                    ph       <= '0;
                end
                // An edge coincident with the tick waits for the next one.
                req <= press_edge;
            end else if (press_edge) begin
                req <= 1'b1;
            end
        end
endmodule

module dot_position_ctrl #(
    parameter int MAX_X        = 580,
    parameter int MAX_Y        = 218,
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] btn_n,
    input  logic       load,
    input  logic [8:0] load_x,
    input  logic [8:0] load_y,
    input  logic       frame_tick,
    output logic [9:0] dot_x,
    output logic [8:0] dot_y,
    output logic       updated
);
    localparam logic signed [10:0] X_HI = 11'(MAX_X - 1);
    localparam logic signed [10:0] Y_HI = 11'(MAX_Y - 1);

    logic [1:0]         rst_ff, warm;
    logic               rst_n;
    logic [3:0]         step;
    logic signed [10:0] dx, dy, nx, ny;
    logic [9:0]         x_next;
    logic [8:0]         y_next;

    assign rst_n = rst_ff[1];

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) rst_ff <= 2'b00;
        else          rst_ff <= {rst_ff[0], 1'b1};

    // Marks the synchronizer outputs as carrying real button samples.
    always_ff @(posedge CLOCK_50 or negedge rst_n)
        if (!rst_n) warm <= 2'b00;
        else        warm <= {warm[0], 1'b1};

    // [0]=right [1]=left [2]=down [3]=up
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_btn
            dot_btn_lane #(
                .DB_CYCLES   (DB_CYCLES),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_lane (
                .clk       (CLOCK_50),
                .rst_n     (rst_n),
                .btn_raw_n (btn_n[i]),
                .warm      (warm[1]),
                .frame_tick(frame_tick),
                .load      (load),
                .step      (step[i])
            );
        end
    endgenerate

    // Next position: clamped load, or clamped signed move.
    always_comb begin
        dx = (step[0] ? 11'sd1 : 11'sd0) - (step[1] ? 11'sd1 : 11'sd0);
        dy = (step[2] ? 11'sd1 : 11'sd0) - (step[3] ? 11'sd1 : 11'sd0);
        nx = $signed({1'b0, dot_x}) + dx;
        ny = $signed({2'b00, dot_y}) + dy;
        x_next = dot_x;
        y_next = dot_y;
        if (load) begin
            x_next = ({1'b0, load_x} > X_HI[9:0]) ? X_HI[9:0] : {1'b0, load_x};
            y_next = (load_y > Y_HI[8:0]) ? Y_HI[8:0] : load_y;
        end else begin
            x_next = (nx < 11'sd0) ? 10'd0 : (nx > X_HI) ? X_HI[9:0] : nx[9:0];
            y_next = (ny < 11'sd0) ? 9'd0  : (ny > Y_HI) ? Y_HI[8:0] : ny[8:0];
        end
    end

    // Coordinate register, written only on frame boundaries.
    always_ff @(posedge CLOCK_50 or negedge rst_n)
        if (!rst_n) begin
            dot_x   <= '0;
            dot_y   <= '0;
            updated <= 1'b0;
        end else if (frame_tick) begin
            dot_x   <= x_next;
            dot_y   <= y_next;
            updated <= (x_next != dot_x) || (y_next != dot_y);
        end else begin
            updated <= 1'b0;
        end
endmodule

// File: tb/tb_dot_position_ctrl.sv
// Bench for dot_position_ctrl: directed button/load stimulus, expected
// coordinates queued per frame tick and checked by a separate monitor.
`timescale 1ns/1ps

module tb_dot_position_ctrl;
    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic [3:0] btn_n    = 4'hF;
    logic       load     = 1'b0;
    logic [8:0] load_x   = '0;
    logic [8:0] load_y   = '0;
    logic       frame_tick = 1'b0;
    logic [9:0] dot_x;
    logic [8:0] dot_y;
    logic       updated;

    dot_position_ctrl #(
        .MAX_X(8), .MAX_Y(6), .DB_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .btn_n     (btn_n),
        .load      (load),
        .load_x    (load_x),
        .load_y    (load_y),
        .frame_tick(frame_tick),
        .dot_x     (dot_x),
        .dot_y     (dot_y),
        .updated   (updated)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       u;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   errors = 0;
    int   checks = 0;
    logic tick_q = 1'b0, probe = 1'b0, probe_q = 1'b0;

    always @(posedge CLOCK_50) begin
        tick_q  <= frame_tick && reset_n;
        probe_q <= probe;
    end

    task automatic cmp(input exp_t e);
        checks++;
        if (dot_x !== e.x || dot_y !== e.y || updated !== e.u) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d upd=%b, required x=%0d y=%0d upd=%b",
                     e.nm, dot_x, dot_y, updated, e.x, e.y, e.u);
        end
    endtask

    // Monitor: pop on every post-tick (or probe) cycle, else updated must be 0.
    always @(negedge CLOCK_50) begin
        if (tick_q || probe_q) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: no expectation queued, got x=%0d y=%0d", dot_x, dot_y);
            end else begin
                me = q.pop_front();
                cmp(me);
            end
        end else begin
            checks++;
            if (updated !== 1'b0) begin
                errors++;
                $display("FAIL idle_updated: got updated=%b, required 0", updated);
            end
        end
    end

    function automatic exp_t mk(input string nm, input int ex, input int ey, input bit eu);
        exp_t e;
        e.x = ex[9:0];
        e.y = ey[8:0];
        e.u = eu;
        e.nm = nm;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic tick(input string nm, input int ex, input int ey, input bit eu);
        @(negedge CLOCK_50);
        q.push_back(mk(nm, ex, ey, eu));
        frame_tick = 1'b1;
        @(negedge CLOCK_50);
        frame_tick = 1'b0;
        idle(18);
    endtask

    task automatic probe_chk(input string nm, input int ex, input int ey, input bit eu);
        @(negedge CLOCK_50);
        q.push_back(mk(nm, ex, ey, eu));
        probe = 1'b1;
        @(negedge CLOCK_50);
        probe = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge CLOCK_50);
        btn_n = b;
        idle(10);
    endtask

    task automatic set_load(input int lx, input int ly);
        @(negedge CLOCK_50);
        load   = 1'b1;
        load_x = lx[8:0];
        load_y = ly[8:0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int rx[10] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    bit ru[10] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        // Reset, with frame ticks that must be ignored.
        idle(2);
        frame_tick = 1'b1;
        idle(3);
        frame_tick = 1'b0;
        probe_chk("reset_hold", 0, 0, 0);
        reset_n = 1'b1;
        idle(8);
        probe_chk("reset_out", 0, 0, 0);

        // Glitches of 1..3 cycles must not debounce.
        btn_n[0] = 1'b0; idle(1); btn_n[0] = 1'b1; idle(2);
        btn_n[0] = 1'b0; idle(2); btn_n[0] = 1'b1; idle(2);
        btn_n[0] = 1'b0; idle(3); btn_n[0] = 1'b1; idle(10);
        tick("glitch", 0, 0, 0);

        // Single clean press of right.
        press(4'b1110);
        tick("right_once", 1, 0, 1);
        press(4'b1111);
        tick("right_released", 1, 0, 0);

        // Auto-repeat over 10 ticks from x=0.
        set_load(0, 0);
        tick("load_zero", 0, 0, 1);
        load = 1'b0;
        press(4'b1110);
        for (int i = 0; i < 10; i++) tick($sformatf("repeat_%0d", i), rx[i], 0, ru[i]);
        press(4'b1111);
        tick("repeat_end", 5, 0, 0);

        // Left and up at the lower bounds, including repeats.
        set_load(0, 0);
        tick("load_origin", 0, 0, 1);
        load = 1'b0;
        press(4'b0101);
        for (int i = 0; i < 5; i++) tick($sformatf("low_bound_%0d", i), 0, 0, 0);
        press(4'b1111);
        tick("low_bound_rel", 0, 0, 0);

        // Right held past the upper bound.
        set_load(6, 0);
        tick("load_six", 6, 0, 1);
        load = 1'b0;
        press(4'b1110);
        tick("to_max", 7, 0, 1);
        for (int i = 0; i < 4; i++) tick($sformatf("hi_bound_%0d", i), 7, 0, 0);
        press(4'b1111);
        tick("hi_bound_rel", 7, 0, 0);

        // Left + right together cancel.
        press(4'b1100);
        tick("cancel", 7, 0, 0);
        press(4'b1111);
        tick("cancel_rel", 7, 0, 0);

        // Load clamps x, discards a pending down request.
        press(4'b1011);
        set_load(300, 4);
        tick("load_clamp", 7, 4, 1);
        load = 1'b0;
        tick("req_dropped_0", 7, 4, 0);
        tick("req_dropped_1", 7, 4, 0);
        press(4'b1111);
        tick("req_dropped_rel", 7, 4, 0);

        // Up then down single steps.
        press(4'b0111);
        tick("up_step", 7, 3, 1);
        press(4'b1111);
        tick("up_rel", 7, 3, 0);
        press(4'b1011);
        tick("down_step", 7, 4, 1);
        press(4'b1111);
        tick("down_rel", 7, 4, 0);

        // Load pulsed between ticks has no effect.
        set_load(2, 1);
        idle(5);
        load = 1'b0;
        idle(5);
        tick("load_between", 7, 4, 0);

        // Reset in the middle of a repeat, button kept held.
        set_load(0, 4);
        tick("load_x0", 0, 4, 1);
        load = 1'b0;
        press(4'b1110);
        tick("pre_rst_0", 1, 4, 1);
        tick("pre_rst_1", 1, 4, 0);
        tick("pre_rst_2", 1, 4, 0);
        tick("pre_rst_3", 2, 4, 1);
        @(negedge CLOCK_50);
        #3;
        reset_n = 1'b0;
        #1;
        cmp(mk("async_reset", 0, 0, 0));
        idle(3);
        reset_n = 1'b1;
        idle(12);
        for (int i = 0; i < 5; i++) tick($sformatf("held_thru_rst_%0d", i), 0, 0, 0);
        press(4'b1111);
        press(4'b1110);
        tick("repress", 1, 0, 1);
        press(4'b1111);
        tick("repress_rel", 1, 0, 0);

        idle(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
